dvi_rx_word_align: RTL

Receive-side TMDS word aligner for one DVI channel. It sits after a 1:5 input deserializer, which is the mirror of the 5:1 output serializer on the transmit side. Each `gclk` it takes one 5-bit slice and assembles 10-bit TMDS symbols. It hunts the bit offset by detecting runs of control tokens, then emits aligned symbols with a lock indication for the downstream TMDS decoder.

---
 rtl/dvi_rx_word_align_if.sv | 36 +++
 rtl/dvi_rx_word_align.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dvi_rx_word_align_if.sv
// ---------------------------------------------------------------------------
// dvi_rx_word_align_if
//
// Bundles the data path of one DVI receive channel word aligner.
//
//   datain    [4:0] deserialized 5-bit slice, datain[0] earliest on the wire
//   sym       [9:0] aligned TMDS symbol, sym[0] first on the wire
//   sym_valid       one-cycle pulse per new symbol while locked
//   is_ctrl         sym is one of the four control tokens
//   ctrl      [1:0] decoded C1:C0 when is_ctrl, else 0
//   locked          word alignment achieved
//   offset    [3:0] current bit offset, 0..9
//
// Modports:
//   master - the deserializer/decoder side: supplies slices, consumes symbols
//   slave  - the aligner itself: consumes slices, produces symbols
// ---------------------------------------------------------------------------
interface dvi_rx_word_align_if;
    logic [4:0] datain;
    logic [9:0] sym;
    logic       sym_valid;
    logic       is_ctrl;
    logic [1:0] ctrl;
    logic       locked;
    logic [3:0] offset;

    modport master (
        output datain,
        input  sym, sym_valid, is_ctrl, ctrl, locked, offset
    );

    modport slave (
        input  datain,
        output sym, sym_valid, is_ctrl, ctrl, locked, offset
    );
endinterface

// File: rtl/dvi_rx_word_align.sv
// ---------------------------------------------------------------------------
// dvi_rx_word_align
//
// Receive-side TMDS word aligner for one DVI channel. Takes one 5-bit slice
// per gclk from a 1:5 deserializer, keeps a 20-bit history and, every second
// cycle, extracts a 10-bit candidate symbol at the current bit offset.
// In HUNT the offset is stepped until CTRL_RUN consecutive control tokens
// are seen at one offset; in LOCKED the symbols are passed on with a valid
// pulse until LOSS_WINDOW symbols go by without any control token.
//
// Ports:
//   gclk    parallel (divided) clock, the only clock
//   resetn  synchronous active-low reset
//   bus     dvi_rx_word_align_if.slave (datain in; sym, sym_valid, is_ctrl,
//           ctrl, locked, offset out)
//
// Parameters:
//   CTRL_RUN        consecutive tokens at one offset needed to lock
//   SEARCH_TIMEOUT  symbols tried at one offset before stepping it
//   LOSS_WINDOW     token-free symbols tolerated while locked
// ---------------------------------------------------------------------------
module dvi_rx_word_align #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOSS_WINDOW    = 4096
) (
    input  logic                 gclk,
    input  logic                 resetn,
    dvi_rx_word_align_if.slave   bus
);

    // Counter widths hold the full parameter value so "reached" is exact.
    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam int SYM_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam int GAP_W = $clog2(LOSS_WINDOW + 1);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CTRL_RUN);
    localparam logic [SYM_W-1:0] SYM_MAX = SYM_W'(SEARCH_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(LOSS_WINDOW);

    // TMDS control tokens, bit 9 down to bit 0.
    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [19:0]      sr;
    logic             phase;
    state_t           state,       state_nxt;
    logic [3:0]       offset,      offset_nxt;
    logic [RUN_W-1:0] run_cnt,     run_cnt_nxt;
    logic [SYM_W-1:0] sym_cnt,     sym_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt,     gap_cnt_nxt;
    logic [9:0]       sym_q,       sym_nxt;
    logic             sym_valid_q, sym_valid_nxt;
    logic             is_ctrl_q,   is_ctrl_nxt;
    logic [1:0]       ctrl_q,      ctrl_nxt;

    // -----------------------------------------------------------------------
    // Candidate extraction and token decode
    // -----------------------------------------------------------------------
    logic [9:0] cand;
    logic       cand_hit;
    logic [1:0] cand_code;

    // sr[0] is the oldest bit, so the window starting at 'offset' is the
    // symbol whose first wire bit sits 'offset' bits into the history.
    assign cand = sr[offset +: 10];

    // NOTE: every always_comb output gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        cand_hit  = 1'b0;
        cand_code = 2'b00;
        case (cand)
            TOK_C00: begin cand_hit = 1'b1; cand_code = 2'b00; end
            TOK_C01: begin cand_hit = 1'b1; cand_code = 2'b01; end
            TOK_C10: begin cand_hit = 1'b1; cand_code = 2'b10; end
            TOK_C11: begin cand_hit = 1'b1; cand_code = 2'b11; end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Saturating counter updates for the symbol being emitted
    // -----------------------------------------------------------------------
    logic [RUN_W-1:0] run_inc;
    logic [SYM_W-1:0] sym_inc;
    logic [GAP_W-1:0] gap_inc;
    logic [3:0]       offset_adv;

    assign run_inc = !cand_hit            ? '0      :
                     (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
    assign sym_inc = (sym_cnt == SYM_MAX) ? sym_cnt : sym_cnt + 1'b1;
    assign gap_inc = cand_hit             ? '0      :
                     (gap_cnt == GAP_MAX) ? gap_cnt : gap_cnt + 1'b1;

    // Offsets run 0..9 and wrap; 10..15 are never used.
    assign offset_adv = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

    // -----------------------------------------------------------------------
    // FSM next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        offset_nxt    = offset;
        run_cnt_nxt   = run_cnt;
        sym_cnt_nxt   = sym_cnt;
        gap_cnt_nxt   = gap_cnt;
        sym_nxt       = sym_q;
        is_ctrl_nxt   = is_ctrl_q;
        ctrl_nxt      = ctrl_q;
        sym_valid_nxt = 1'b0;

        if (phase) begin
            // Emit cycle: sym, is_ctrl and ctrl move together.
            sym_nxt     = cand;
            is_ctrl_nxt = cand_hit;
            ctrl_nxt    = cand_hit ? cand_code : 2'b00;

            case (state)
                HUNT: begin
                    run_cnt_nxt = run_inc;
                    sym_cnt_nxt = sym_inc;
                    // Lock wins over a timeout landing on the same symbol.
                    if (run_inc == RUN_MAX) begin
                        state_nxt   = LOCKED;
                        gap_cnt_nxt = '0;
                    end else if (sym_inc == SYM_MAX) begin
                        offset_nxt  = offset_adv;
                        run_cnt_nxt = '0;
                        sym_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (gap_inc == GAP_MAX) begin
                        state_nxt   = HUNT;
                        offset_nxt  = offset_adv;
                        run_cnt_nxt = '0;
                        sym_cnt_nxt = '0;
                        gap_cnt_nxt = '0;
                    end else begin
                        gap_cnt_nxt = gap_inc;
                    end
                end
                default: state_nxt = HUNT;
            endcase

            // The pulse follows the lock state after this edge: the locking
            // token gets one, the symbol that drops lock does not.
            sym_valid_nxt = (state_nxt == LOCKED);
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge gclk) begin
        if (!resetn) begin
            sr          <= '0;
            phase       <= 1'b0;
            state       <= HUNT;
            offset      <= 4'd0;
            run_cnt     <= '0;
            sym_cnt     <= '0;
            gap_cnt     <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            is_ctrl_q   <= 1'b0;
            ctrl_q      <= 2'b00;
        end else begin
            sr          <= {bus.datain, sr[19:5]};
            phase       <= ~phase;
            state       <= state_nxt;
            offset      <= offset_nxt;
            run_cnt     <= run_cnt_nxt;
            sym_cnt     <= sym_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            sym_q       <= sym_nxt;
            sym_valid_q <= sym_valid_nxt;
            is_ctrl_q   <= is_ctrl_nxt;
            ctrl_q      <= ctrl_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.sym       = sym_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.is_ctrl   = is_ctrl_q;
    assign bus.ctrl      = ctrl_q;
    assign bus.locked    = (state == LOCKED);
    assign bus.offset    = offset;

endmodule
